// File: rtl/pkt_tx_checker.sv
`default_nettype none
// ============================================================================
// Module   : pkt_tx_checker
// Brief    : Frame checker for the forwarding stage's byte stream; queues
//            {xor, length} descriptors of good frames behind a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_tx_checker #(
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 512,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  addr,
    input  logic [31:0] din,
    input  logic        rw,
    input  logic        enable,
    output logic [31:0] dout,
    input  logic [7:0]  rxd,
    input  logic        rx_vld,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [9:0]  out_len,
    output logic [7:0]  out_xor
);

    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [9:0]    MIN_L    = 10'(MIN_LEN);
    localparam logic [9:0]    MAX_L    = 10'(MAX_LEN);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE1 = 2'd1,
        S_BODY = 2'd2,
        S_BAD  = 2'd3
    } state_t;

    state_t        state;
    logic [9:0]    len;
    logic [7:0]    xsum;
    logic          chk_en;
    logic [15:0]   good_cnt;
    logic [15:0]   bad_cnt;
    logic [15:0]   drop_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [17:0]   mem [FIFO_DEPTH];

    logic          bus_wr;
    logic          clr_cnt;
    logic          pop;
    logic          frame_end;
    logic          len_ok;
    logic          good_end;
    logic          push;
    logic          inc_good;
    logic          inc_bad;
    logic          inc_drop;
    logic [17:0]   push_data;
    logic [AW-1:0] rd_nxt;
    logic [AW:0]   count_nxt;
    logic [17:0]   head_nxt;
    logic          unused_din;

    assign unused_din = ^din[31:2];

    assign bus_wr    = enable & ~rw;
    assign clr_cnt   = bus_wr && (addr == 8'h00) && din[1];
    assign out_vld   = (count != '0);
    assign pop       = out_vld & out_rdy;
    assign frame_end = (state == S_BODY) && !rx_vld;
    assign len_ok    = (len >= MIN_L) && (len <= MAX_L);
    assign good_end  = frame_end && len_ok;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push      = good_end && ((count != FULL_CNT) || pop);
    assign inc_good  = push;
    assign inc_drop  = good_end && !push;
    assign inc_bad   = (frame_end && !len_ok) ||
                       (((state == S_PRE1) || (state == S_BAD)) && !rx_vld);
    assign push_data = {xsum, len};

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            len   <= 10'd0;
            xsum  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_vld && chk_en) begin
                        len   <= 10'd1;
                        xsum  <= 8'd0;
                        state <= (rxd == 8'h55) ? S_PRE1 : S_BAD;
                    end
                end
                S_PRE1: begin
                    if (rx_vld) begin
                        len   <= len + 10'd1;
                        state <= (rxd == 8'hD5) ? S_BODY : S_BAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_BODY: begin
                    if (rx_vld) begin
                        if (len != 10'h3FF) begin
                            len <= len + 10'd1;
                        end
                        xsum <= xsum ^ rxd;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_BAD: begin
                    if (!rx_vld) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_en   <= 1'b0;
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (bus_wr && (addr == 8'h00)) begin
                chk_en <= din[0];
            end
            if (clr_cnt) begin
                good_cnt <= 16'd0;
                bad_cnt  <= 16'd0;
                drop_cnt <= 16'd0;
            end else begin
                if (inc_good) good_cnt <= sat_inc(good_cnt);
                if (inc_bad)  bad_cnt  <= sat_inc(bad_cnt);
                if (inc_drop) drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (!push && pop) begin
            count_nxt = count - CNT_ONE;
        end
    end

    assign rd_nxt = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    // Bypass covers the entry being written this edge becoming the new head.
    assign head_nxt = (push && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            out_len <= 10'd0;
            out_xor <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr <= rd_nxt;
            count  <= count_nxt;
            if (count_nxt != '0) begin
                out_len <= head_nxt[9:0];
                out_xor <= head_nxt[17:10];
            end
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            8'h00:   dout = {31'd0, chk_en};
            8'h04:   dout = {16'd0, good_cnt};
            8'h08:   dout = {16'd0, bad_cnt};
            8'h0C:   dout = {16'd0, drop_cnt};
            8'h10:   dout = {{(31 - AW){1'b0}}, count};
            default: dout = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_pkt_tx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_tx_checker
// Brief    : Scoreboard bench for pkt_tx_checker with directed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_tx_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [31:0] din;
    logic        rw;
    logic        enable;
    logic [31:0] dout;
    logic [7:0]  rxd;
    logic        rx_vld;
    logic        out_vld;
    logic        out_rdy;
    logic [9:0]  out_len;
    logic [7:0]  out_xor;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    pkt_tx_checker #(
        .MIN_LEN    (64),
        .MAX_LEN    (512),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .din     (din),
        .rw      (rw),
        .enable  (enable),
        .dout    (dout),
        .rxd     (rxd),
        .rx_vld  (rx_vld),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_len (out_len),
        .out_xor (out_xor)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        chk(name, dout, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr   = a;
        din    = d;
        rw     = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        rw     = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_vld = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] fbyte(input int i, input logic [7:0] b0,
                                         input logic [7:0] b1, input int seed);
        if (i == 0) return b0;
        if (i == 1) return b1;
        return 8'((seed + i - 2) & 255);
    endfunction

    // Leaves rx_vld low; the frame-end edge is the next posedge.
    task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input int seed, input bit rdy_at_end);
        for (int i = 0; i < n; i++) begin
            rxd    = fbyte(i, b0, b1, seed);
            rx_vld = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_vld = 1'b0;
        rxd    = 8'h00;
        if (rdy_at_end) out_rdy = 1'b1;
    endtask

    task automatic drain(input int budget, input string name);
        out_rdy = 1'b1;
        for (int k = 0; k < budget && exp_q.size() != 0; k++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d descriptors outstanding, expected 0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
        chk({name, "_vld_low"}, out_vld, 0);
    endtask

    initial begin : monitor
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_desc: got len=%0d xor=0x%0h, expected none",
                             out_len, out_xor);
                end else begin
                    e = exp_q.pop_front();
                    chk("desc", {14'd0, out_xor, out_len}, {14'd0, e});
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        addr = 8'h00; din = 32'd0; rw = 1'b1; enable = 1'b0;
        rxd = 8'h00; rx_vld = 1'b0; out_rdy = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_out_xor", out_xor, 0);
        rd_chk(8'h00, 0, "rst_ctrl");
        rd_chk(8'h04, 0, "rst_good");
        rd_chk(8'h08, 0, "rst_bad");
        rd_chk(8'h0C, 0, "rst_drop");
        rd_chk(8'h10, 0, "rst_fifo");
        rd_chk(8'h20, 0, "unmapped");

        wr(8'h00, 32'h1);
        rd_chk(8'h00, 1, "ctrl_en");

        // Minimum-length good frame: payload 0x00..0x3D XORs to 0x01
        send_frame(64, 8'h55, 8'hD5, 0, 1'b0);
        chk("t1_vld_before_end", out_vld, 0);
        @(posedge clk);
        #1;
        chk("t1_vld", out_vld, 1);
        chk("t1_len", out_len, 64);
        chk("t1_xor", out_xor, 8'h01);
        exp_q.push_back({8'h01, 10'd64});
        rd_chk(8'h04, 1, "t1_good");
        rd_chk(8'h10, 1, "t1_fifo");
        drain(20, "t1");
        chk("t1_len_hold", out_len, 64);

        // Maximum-length good frame: payload wraps 0..255,0..253 -> 0x01
        send_frame(512, 8'h55, 8'hD5, 0, 1'b0);
        exp_q.push_back({8'h01, 10'd512});
        idle(2);
        drain(20, "t512");
        rd_chk(8'h04, 2, "t512_good");

        out_rdy = 1'b0;
        send_frame(64, 8'h54, 8'hD5, 0, 1'b0);
        idle(2);
        rd_chk(8'h08, 1, "badpre_bad");
        chk("badpre_vld", out_vld, 0);
        send_frame(63, 8'h55, 8'hD5, 0, 1'b0);
        idle(2);
        rd_chk(8'h08, 2, "short_bad");
        send_frame(513, 8'h55, 8'hD5, 0, 1'b0);
        idle(2);
        rd_chk(8'h08, 3, "long_bad");
        send_frame(1, 8'h55, 8'hD5, 0, 1'b0);
        idle(2);
        rd_chk(8'h08, 4, "single_bad");
        rd_chk(8'h04, 2, "bads_good");
        rd_chk(8'h0C, 0, "bads_drop");
        chk("bads_vld", out_vld, 0);

        // Fill with backpressure; payload seeds give xor 0x01,0x63,0x01,0x67
        wr(8'h00, 32'h3);
        rd_chk(8'h04, 0, "clr_good");
        rd_chk(8'h08, 0, "clr_bad");
        rd_chk(8'h00, 1, "clr_ctrl");
        send_frame(100, 8'h55, 8'hD5, 0, 1'b0); exp_q.push_back({8'h01, 10'd100}); idle(2);
        send_frame(100, 8'h55, 8'hD5, 1, 1'b0); exp_q.push_back({8'h63, 10'd100}); idle(2);
        send_frame(100, 8'h55, 8'hD5, 2, 1'b0); exp_q.push_back({8'h01, 10'd100}); idle(2);
        send_frame(100, 8'h55, 8'hD5, 3, 1'b0); exp_q.push_back({8'h67, 10'd100}); idle(2);
        send_frame(100, 8'h55, 8'hD5, 4, 1'b0); idle(2);
        rd_chk(8'h04, 4, "full_good");
        rd_chk(8'h0C, 1, "full_drop");
        rd_chk(8'h10, 4, "full_fifo");
        chk("full_head_len", out_len, 100);
        chk("full_head_xor", out_xor, 8'h01);

        // Push into a full FIFO on the same edge as a pop
        send_frame(64, 8'h55, 8'hD5, 0, 1'b1);
        exp_q.push_back({8'h01, 10'd64});
        @(posedge clk);
        #1;
        out_rdy = 1'b0;
        rd_chk(8'h10, 4, "pp_fifo");
        rd_chk(8'h0C, 1, "pp_drop");
        rd_chk(8'h04, 5, "pp_good");
        chk("pp_head_xor", out_xor, 8'h63);
        drain(40, "pp");
        rd_chk(8'h10, 0, "pp_fifo_empty");

        // Checker disabled: frames ignored
        wr(8'h00, 32'h0);
        send_frame(64, 8'h55, 8'hD5, 0, 1'b0);
        idle(2);
        rd_chk(8'h04, 5, "dis_good");
        rd_chk(8'h08, 0, "dis_bad");
        rd_chk(8'h0C, 1, "dis_drop");
        chk("dis_vld", out_vld, 0);
        wr(8'h00, 32'h2);
        rd_chk(8'h04, 0, "clr2_good");
        rd_chk(8'h0C, 0, "clr2_drop");
        rd_chk(8'h00, 0, "clr2_ctrl");

        // Reset in the middle of a frame
        wr(8'h00, 32'h1);
        send_frame(64, 8'h54, 8'hD5, 0, 1'b0);
        idle(2);
        out_rdy = 1'b0;
        send_frame(64, 8'h55, 8'hD5, 0, 1'b0);
        exp_q.push_back({8'h01, 10'd64});
        idle(2);
        rd_chk(8'h10, 1, "pre_rst_fifo");
        rd_chk(8'h08, 1, "pre_rst_bad");
        for (int i = 0; i < 100; i++) begin
            rxd    = fbyte(i, 8'h55, 8'hD5, 0);
            rx_vld = 1'b1;
            if (i == 30) begin
                rst_n = 1'b0;
                exp_q.delete();
            end
            if (i == 31) begin
                chk("inrst_vld", out_vld, 0);
                chk("inrst_len", out_len, 0);
                chk("inrst_xor", out_xor, 0);
                rd_chk(8'h00, 0, "inrst_ctrl");
                rd_chk(8'h04, 0, "inrst_good");
                rd_chk(8'h08, 0, "inrst_bad");
                rd_chk(8'h10, 0, "inrst_fifo");
            end
            if (i == 32) rst_n = 1'b1;
            if (i == 33) begin
                addr = 8'h00; din = 32'h1; rw = 1'b0; enable = 1'b1;
            end
            if (i == 34) begin
                enable = 1'b0; rw = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        idle(2);
        rd_chk(8'h08, 1, "tail_bad");
        rd_chk(8'h04, 0, "tail_good");
        out_rdy = 1'b1;
        send_frame(64, 8'h55, 8'hD5, 0, 1'b0);
        exp_q.push_back({8'h01, 10'd64});
        idle(2);
        drain(20, "post_rst");
        rd_chk(8'h04, 1, "post_rst_good");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_tx_checker.md
Name: pkt_tx_checker

Overview:
- Downstream consumer of the packet forwarding stage's txd/tx_vld byte stream.
- Delineates frames, checks the 0x55/0xD5 preamble and the length bounds, and computes an XOR checksum over the payload.
- Pushes a {checksum, length} descriptor per good frame into a small FIFO with a valid/ready output.
- Exposes enable and statistics registers on the same addr/din/rw/enable/dout bus style as the forwarding stage.

Parameters:
- MIN_LEN, 64, minimum good total frame length in bytes (preamble included).
- MAX_LEN, 512, maximum good total frame length in bytes (preamble included).
- FIFO_DEPTH, 4, descriptor FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- addr  input  8  register address.
- din  input  32  register write data.
- rw  input  1  0=write, 1=read.
- enable  input  1  bus access strobe; write = enable&!rw.
- dout  output  32  register read data; combinational on addr.
- rxd  input  8  frame byte, driven by upstream txd.
- rx_vld  input  1  byte valid; a frame is a contiguous high run, frames separated by >=1 low cycle.
- out_vld  output  1  descriptor available.
- out_rdy  input  1  consumer accepts descriptor.
- out_len  output  10  total frame length of head descriptor.
- out_xor  output  8  XOR of payload bytes (bytes after 0xD5) of head descriptor.

Behaviour:
- Reset (async): state=IDLE; all counters, FIFO pointers and count 0; chk_en=0; out_vld=0; out_len=0; out_xor=0.
- Registers:
  - 0x00 ctrl: bit0 chk_en (R/W). bit1 clr_cnt, write-1 self-clearing, reads 0.
  - 0x04 good_cnt (RO).
  - 0x08 bad_cnt (RO).
  - 0x0C drop_cnt (RO).
  - 0x10 fifo_cnt (RO, low bits).
  - Other addresses read 0.
  - Counters are 16-bit, saturate at 0xFFFF, zero-extended on read.
  - clr_cnt zeroes good/bad/drop on the write edge and takes priority over a same-cycle increment.
- Byte counter len: 10 bits, saturates at 1023. xor: 8 bits.
- FSM, all transitions on clk:
  - IDLE: on rx_vld&chk_en, len<=1, xor<=0. Go to PRE1 if rxd==0x55, else BAD. Without chk_en, bytes are ignored; a frame already in progress when chk_en clears still completes.
  - PRE1:
    - rx_vld: len++; go to BODY if rxd==0xD5, else BAD.
    - !rx_vld: bad_cnt++, go to IDLE.
  - BODY:
    - rx_vld: len++ (saturating), xor^=rxd.
    - !rx_vld (frame end): if MIN_LEN<=len<=MAX_LEN, the frame is good; otherwise bad_cnt++. Go to IDLE.
    - Good frame: if the FIFO can accept (not full, or a pop happens in the same cycle), push {xor,len} and good_cnt++. Otherwise drop_cnt++ and nothing is pushed.
  - BAD: wait for !rx_vld, then bad_cnt++ and go to IDLE.
- A frame started in IDLE with rx_vld high for one cycle only (single byte 0x55) counts as bad via PRE1.
- FIFO:
  - First-word-fall-through. out_vld = (count!=0).
  - out_len/out_xor show the head entry, and hold their last value when empty.
  - Pop on out_vld&out_rdy.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: the push happens on the edge that samples the first low rx_vld after a frame; out_vld rises on that same edge when the FIFO was empty.
- rst_n assertion mid-frame aborts the frame with no counter update. After release, the remainder of the aborted frame is treated as a new frame and counted bad (first byte != 0x55).

Test Plan:
- chk_en=1; frame 0x55,0xD5,0x00..0x3D (64 bytes) -> out_vld=1 one edge after rx_vld falls; out_len=64, out_xor=0x01; good_cnt=1.
- Frame with first byte 0x54, 64 bytes -> bad_cnt=1, out_vld stays 0. Valid-preamble 63-byte frame -> bad_cnt=2. 513-byte frame -> bad_cnt=3.
- out_rdy=0; five good 100-byte frames -> good_cnt=4, drop_cnt=1, fifo_cnt=4. Then out_rdy=1 -> four descriptors of len 100 in order, then out_vld=0.
- chk_en=0; good frame -> no counter change, out_vld=0. Then write 0x02 to 0x00 -> good/bad/drop read 0.
- rst_n pulsed low at byte 30 of a frame -> all registers and outputs at reset values. After re-enabling chk_en, the tail of the aborted frame -> bad_cnt=1. The next clean frame is accepted.
- Pop and push on the same edge with the FIFO full -> push accepted, fifo_cnt stays 4, drop_cnt unchanged.
